// File: rtl/mips_int_pkg.sv
// Shared constants for the MIPS interrupt controller: FSM encoding,
// register map and the default number of sources.
package mips_int_pkg;

  localparam int NSRC_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_PEND = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;

endpackage

// File: rtl/int_prio_enc.sv
// Combinational priority encoder: the lowest set bit of req wins.
module int_prio_enc #(
  parameter int NSRC = 8
) (
  input  logic [NSRC-1:0]         req,
  output logic                    any,
  output logic [$clog2(NSRC)-1:0] idx
);

  // Scanning from the top down lets the lowest set index overwrite the rest.
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) idx = i[$clog2(NSRC)-1:0];
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-detected pending bits, per-source mask, global
// enable, one prioritized request with ack/eret handshake, 4-word reg file.
module int_ctrl
  import mips_int_pkg::*;
#(
  parameter int NSRC = NSRC_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NSRC-1:0]         irq_in,
  input  logic                    we,
  input  logic [1:0]              addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    int_req,
  output logic [$clog2(NSRC)-1:0] int_vec,
  input  logic                    int_ack,
  input  logic                    eret
);

  localparam int VW = $clog2(NSRC);

  logic [NSRC-1:0] irq_prev_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] mask_q;
  logic            ge_q;
  logic [NSRC-1:0] edge_set, w1c_clr, ack_clr;
  logic            ack_take;
  state_e          state_q, state_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic [VW-1:0]   win_idx;
  logic            win_any;
  logic            unused_wdata;

  assign unused_wdata = ^wdata[31:NSRC];

  assign edge_set = irq_in & ~irq_prev_q;
  assign ack_take = (state_q == ST_REQ) && int_ack;

  int_prio_enc #(.NSRC(NSRC)) u_prio (
    .req (pending_q & mask_q),
    .any (win_any),
    .idx (win_idx)
  );

  // Clears are applied before sets so a coincident edge keeps the bit set.
  always_comb begin
    w1c_clr = '0;
    ack_clr = '0;
    if (we && addr == ADDR_PEND) w1c_clr = wdata[NSRC-1:0];
    if (ack_take) ack_clr[vec_q] = 1'b1;
    pending_d = (pending_q & ~(w1c_clr | ack_clr)) | edge_set;
  end

  // irq_prev tracks irq_in even in reset so held levels are not seen as edges.
  always_ff @(posedge clk) begin
    irq_prev_q <= irq_in;
    if (reset) begin
      pending_q <= '0;
      mask_q    <= '0;
      ge_q      <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (we && addr == ADDR_MASK) mask_q <= wdata[NSRC-1:0];
      if (we && addr == ADDR_CTRL) ge_q   <= wdata[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      ST_IDLE: begin
        if (ge_q && win_any) begin
          state_d = ST_REQ;
          vec_d   = win_idx;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          state_d = ST_SVC;
        end else if (!pending_d[vec_q] || !mask_q[vec_q] || !ge_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_SVC: begin
        if (eret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    int_req = (state_q == ST_REQ);
    int_vec = vec_q;
  end

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_PEND: rdata[NSRC-1:0] = pending_q;
      ADDR_MASK: rdata[NSRC-1:0] = mask_q;
      ADDR_CTRL: rdata[0]        = ge_q;
      ADDR_STAT: begin
        rdata[1:0]    = state_q;
        rdata[4 +: VW] = vec_q;
      end
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl; each task drives one scenario
// and compares against hand-computed values.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  irq_in = '0;
  logic        we = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        int_req;
  logic [2:0]  int_vec;
  logic        int_ack = 1'b0;
  logic        eret = 1'b0;

  int tests = 0;
  int fails = 0;

  int_ctrl #(.NSRC(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_in  (irq_in),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .int_req (int_req),
    .int_vec (int_vec),
    .int_ack (int_ack),
    .eret    (eret)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    irq_in = 8'hFF;
    reset  = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    tests++;
    if (int_req !== 1'b0) begin fails++; $display("FAIL reset_req got=%b exp=0", int_req); end
    tests++;
    if (int_vec !== 3'd0) begin fails++; $display("FAIL reset_vec got=%0d exp=0", int_vec); end
    rd(2'd0, d);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL reset_pending got=%h exp=0", d); end
    rd(2'd1, d);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL reset_mask got=%h exp=0", d); end
    rd(2'd3, d);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL reset_status got=%h exp=0", d); end
    irq_in = 8'h00;
    step();
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic();
    logic [31:0] d;
    wr(2'd1, 32'h01);
    wr(2'd2, 32'h01);
    irq_in = 8'h01;
    step();
    irq_in = 8'h00;
    tests++;
    if (int_req !== 1'b0) begin fails++; $display("FAIL basic_early_req got=%b exp=0", int_req); end
    step();
    tests++;
    if (int_req !== 1'b1 || int_vec !== 3'd0) begin
      fails++; $display("FAIL basic_req got=%b/%0d exp=1/0", int_req, int_vec);
    end
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    tests++;
    if (int_req !== 1'b0) begin fails++; $display("FAIL basic_ack_req got=%b exp=0", int_req); end
    rd(2'd0, d);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL basic_ack_pending got=%h exp=0", d); end
    rd(2'd3, d);
    tests++;
    if (d !== 32'h02) begin fails++; $display("FAIL basic_svc_status got=%h exp=02", d); end
    eret = 1'b1;
    step();
    eret = 1'b0;
    rd(2'd3, d);
    tests++;
    if (d !== 32'h00) begin fails++; $display("FAIL basic_eret_status got=%h exp=00", d); end
    $display("[TB] test_basic done");
  endtask

  task automatic test_priority();
    logic [31:0] d;
    wr(2'd1, 32'hFF);
    irq_in = 8'h24;
    step();
    irq_in = 8'h00;
    step();
    tests++;
    if (int_req !== 1'b1 || int_vec !== 3'd2) begin
      fails++; $display("FAIL prio_first got=%b/%0d exp=1/2", int_req, int_vec);
    end
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    rd(2'd3, d);
    tests++;
    if (d !== 32'h22) begin fails++; $display("FAIL prio_svc_status got=%h exp=22", d); end
    rd(2'd0, d);
    tests++;
    if (d !== 32'h20) begin fails++; $display("FAIL prio_pending got=%h exp=20", d); end
    eret = 1'b1;
    step();
    eret = 1'b0;
    tests++;
    if (int_req !== 1'b0) begin fails++; $display("FAIL prio_eret_req got=%b exp=0", int_req); end
    step();
    tests++;
    if (int_req !== 1'b1 || int_vec !== 3'd5) begin
      fails++; $display("FAIL prio_second got=%b/%0d exp=1/5", int_req, int_vec);
    end
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    eret = 1'b1;
    step();
    eret = 1'b0;
    $display("[TB] test_priority done");
  endtask

  task automatic test_mask();
    logic [31:0] d;
    wr(2'd1, 32'h00);
    irq_in = 8'h08;
    step();
    irq_in = 8'h00;
    step();
    rd(2'd0, d);
    tests++;
    if (d !== 32'h08) begin fails++; $display("FAIL mask_pending got=%h exp=08", d); end
    tests++;
    if (int_req !== 1'b0) begin fails++; $display("FAIL mask_noreq got=%b exp=0", int_req); end
    wr(2'd1, 32'h08);
    tests++;
    if (int_req !== 1'b0) begin fails++; $display("FAIL mask_write_edge got=%b exp=0", int_req); end
    step();
    tests++;
    if (int_req !== 1'b1 || int_vec !== 3'd3) begin
      fails++; $display("FAIL mask_unmask got=%b/%0d exp=1/3", int_req, int_vec);
    end
    wr(2'd0, 32'h08);
    tests++;
    if (int_req !== 1'b0) begin fails++; $display("FAIL mask_w1c_withdraw got=%b exp=0", int_req); end
    $display("[TB] test_mask done");
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    wr(2'd1, 32'h00);
    irq_in = 8'h01;
    step();
    irq_in = 8'h00;
    step();
    addr   = 2'd0;
    wdata  = 32'h01;
    we     = 1'b1;
    irq_in = 8'h01;
    step();
    we     = 1'b0;
    irq_in = 8'h00;
    rd(2'd0, d);
    tests++;
    if (d !== 32'h01) begin fails++; $display("FAIL setwins_pending got=%h exp=01", d); end
    wr(2'd0, 32'h01);
    rd(2'd0, d);
    tests++;
    if (d !== 32'h00) begin fails++; $display("FAIL w1c_plain got=%h exp=00", d); end
    $display("[TB] test_set_wins done");
  endtask

  task automatic test_ge();
    logic [31:0] d;
    wr(2'd1, 32'h01);
    irq_in = 8'h01;
    step();
    irq_in = 8'h00;
    step();
    tests++;
    if (int_req !== 1'b1) begin fails++; $display("FAIL ge_req got=%b exp=1", int_req); end
    wr(2'd2, 32'h00);
    tests++;
    if (int_req !== 1'b1) begin fails++; $display("FAIL ge_hold got=%b exp=1", int_req); end
    step();
    tests++;
    if (int_req !== 1'b0) begin fails++; $display("FAIL ge_withdraw got=%b exp=0", int_req); end
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    rd(2'd0, d);
    tests++;
    if (d !== 32'h01) begin fails++; $display("FAIL ack_idle_ignored got=%h exp=01", d); end
    wr(2'd0, 32'h01);
    wr(2'd2, 32'h01);
    $display("[TB] test_ge done");
  endtask

  task automatic test_withdraw();
    logic [31:0] d;
    wr(2'd1, 32'h02);
    irq_in = 8'h02;
    step();
    irq_in = 8'h00;
    step();
    tests++;
    if (int_req !== 1'b1 || int_vec !== 3'd1) begin
      fails++; $display("FAIL wd_req got=%b/%0d exp=1/1", int_req, int_vec);
    end
    wr(2'd0, 32'h02);
    tests++;
    if (int_req !== 1'b0) begin fails++; $display("FAIL wd_drop got=%b exp=0", int_req); end
    rd(2'd3, d);
    tests++;
    if (d !== 32'h10) begin fails++; $display("FAIL wd_status got=%h exp=10", d); end
    $display("[TB] test_withdraw done");
  endtask

  task automatic test_reset_svc();
    logic [31:0] d;
    irq_in = 8'h02;
    step();
    irq_in = 8'h00;
    step();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    rd(2'd3, d);
    tests++;
    if (d !== 32'h12) begin fails++; $display("FAIL rsvc_status got=%h exp=12", d); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++;
    if (int_req !== 1'b0) begin fails++; $display("FAIL rsvc_req got=%b exp=0", int_req); end
    rd(2'd3, d);
    tests++;
    if (d !== 32'h00) begin fails++; $display("FAIL rsvc_state got=%h exp=00", d); end
    eret = 1'b1;
    step();
    eret = 1'b0;
    rd(2'd3, d);
    tests++;
    if (d !== 32'h00 || int_req !== 1'b0) begin
      fails++; $display("FAIL rsvc_eret got=%h/%b exp=00/0", d, int_req);
    end
    $display("[TB] test_reset_svc done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_set_wins();
    test_ge();
    test_withdraw();
    test_reset_svc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller for the MIPS test system. It sits directly downstream of the interval counter: the counter's `c_int` drives `irq_in[0]`, and up to seven further sources use the remaining bits. The block edge-detects the sources into a pending register and applies per-source masking and a global enable. It then presents one prioritized request to the CPU with an ack/eret handshake, and exposes a small memory-mapped register file.

## Interface
Parameters:
- `NSRC`, 8: number of interrupt sources; `int_vec` width is clog2(NSRC).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `irq_in`  in  NSRC  raw sources; bit 0 = counter `c_int`.
- `we`  in  1  register write strobe.
- `addr`  in  2  register select.
- `wdata`  in  32  write data.
- `rdata`  out  32  combinational read of the register at `addr`.
- `int_req`  out  1  registered interrupt request to the CPU.
- `int_vec`  out  clog2(NSRC)  index of the requested source; valid while `int_req` is high.
- `int_ack`  in  1  CPU accepts the request.
- `eret`  in  1  CPU leaves the handler.

## Operation
- Registers:
  - addr 0 PENDING: read; write-1-to-clear.
  - addr 1 MASK: read/write; bit=1 enables the source.
  - addr 2 CTRL: bit0 = GE, the global enable.
  - addr 3 STATUS: read-only; [1:0] state, [7:4] latched vec.
  - Unused bits read 0.
- Edge detect: `irq_prev` is updated every cycle. `pending[i]` is set when `irq_in[i] & ~irq_prev[i]`.
  - A source held high sets pending only once. A counter with val=0 holds `c_int` high, so it yields one edge.
- Simultaneous set and clear on the same bit (W1C or ack-clear): set wins.
- Priority: the lowest set index of `pending & MASK` wins.
- FSM states: IDLE=0, REQ=1, SVC=2.
  - IDLE: if GE & |(pending & MASK), latch the winning index into vec, raise `int_req`, go to REQ.
  - REQ: `int_req`=1 and `int_vec`=vec.
    - On `int_ack`: clear pending[vec], drop `int_req`, go to SVC.
    - Else if pending[vec] is cleared by W1C, or MASK[vec]=0, or GE=0: drop `int_req`, go to IDLE (withdraw).
    - A higher-priority arrival in REQ does not change vec.
  - SVC: `int_req`=0, so no nesting. Pending bits still accumulate. On `eret`, go to IDLE.
  - `int_ack` outside REQ and `eret` outside SVC are ignored.
- Reset state:
  - pending, MASK and GE = 0; state = IDLE; vec = 0.
  - Outputs: `int_req`=0, `int_vec`=0.
  - `irq_prev` loads `irq_in` during reset, so levels already high at release are not edges.
  - Reset in any state, including mid-SVC, returns to IDLE in the same cycle with `int_req`=0.

## Timing
- Latency: source rises at posedge k → pending set after k → `int_req` high after posedge k+1.
- Ack: `int_ack` sampled high at posedge m → `int_req` low and pending[vec] cleared after m.
- After `eret` at posedge e, a further eligible request raises `int_req` after posedge e+1.
- Register writes take effect after the writing edge. A MASK/GE change is seen by the IDLE decision on the next edge.
- `rdata` is combinational from current register state, with no wait states.

## Structure
- Package `mips_int_pkg` holds:
  - the state encoding constants (IDLE/REQ/SVC);
  - the register address constants (ADDR_PEND, ADDR_MASK, ADDR_CTRL, ADDR_STAT);
  - the default NSRC.
- Sub-module `int_prio_enc`: combinational lowest-index priority encoder.
  - Input: NSRC-bit vector.
  - Outputs: `any` and `idx`.
- Everything else (edge detect, registers, FSM) lives in `int_ctrl`.

## Test plan
- Reset/defaults: assert reset 2 cycles with `irq_in`=0xFF → after release `int_req`=0, `int_vec`=0, PENDING reads 0x00 (no edges), MASK=0, STATUS=0.
- Basic path: MASK=0x01, GE=1, one-cycle pulse on `irq_in[0]` at posedge k → `int_req`=1 and `int_vec`=0 after k+1.
  - Then `int_ack` → `int_req`=0, PENDING=0x00, STATUS state=2.
  - Then `eret` → state=0.
- Priority: MASK=0xFF, GE=1, edges on bits 5 and 2 in the same cycle → `int_vec`=2 first. After ack+eret, `int_vec`=5 two cycles later.
- Masking: MASK=0x00, GE=1, edge on bit 3 → PENDING=0x08 and no `int_req`. Write MASK=0x08 → `int_req`=1 with `int_vec`=3 after the following edge.
- Set-wins race: pending bit0=1; write PENDING=0x01 in the same cycle as a new rising edge on `irq_in[0]` → PENDING still reads 0x01.
- Withdraw and mid-operation reset:
  - In REQ for vec 1, W1C PENDING=0x02 → `int_req` drops next cycle and state=0.
  - Separately, assert `reset` while in SVC → state=0 and `int_req`=0 after that edge; a subsequent `eret` has no effect.
